psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
// - Drain side of the pointwise systolic array: accepts INTER_BITWIDTH partial sums leaving a column's last MAC.
// - Requantizes each sum (round, arithmetic shift, saturate) to ACT_BITWIDTH activations.
// - Buffers results in a FIFO and streams them out over valid/ready.
// - Counts a programmed number of outputs per job, then pulses done.
// PARAMETERS
// - INTER_BITWIDTH  65  width of incoming partial sum (signed)
// - ACT_BITWIDTH    16  width of outgoing activation (signed)
// - SHIFT_BITWIDTH  6   width of cfg_shift
// - CNT_BITWIDTH    16  width of cfg_num_out and internal counters
// - FIFO_DEPTH      8   output FIFO entries (power of 2, >=2)
// PORTS
// - clk          in   1               rising-edge clock
// - reset        in   1               synchronous, active-high
// - start        in   1               1-cycle pulse; latches cfg_*, honoured only in IDLE
// - cfg_shift    in   SHIFT_BITWIDTH  right-shift amount, 0..63
// - cfg_num_out  in   CNT_BITWIDTH    outputs in this job; 0 => immediate done
// - psum_valid   in   1               psum_in valid
// - psum_ready   out  1               drain can accept psum_in
// - psum_in      in   INTER_BITWIDTH  partial sum, two's complement
// - act_valid    out  1               act_out valid
// - act_ready    in   1               downstream accepts act_out
// - act_out      out  ACT_BITWIDTH    requantized activation
// - busy         out  1               state != IDLE
// - done         out  1               1-cycle pulse at job end
// - sat_flag     out  1               sticky: any saturation this job; cleared on accepted start
// BEHAVIOUR
// - Reset: state=IDLE, FIFO and pipeline flushed, counters 0; psum_ready=0, act_valid=0, act_out=0, busy=0, done=0, sat_flag=0.
// - Reset mid-job: same as above; in-flight and buffered data discarded, no done pulse.
// - FSM: IDLE -start-> DRAIN (cfg_num_out=0: IDLE -start-> DONE); DRAIN -> DONE on the cycle the cfg_num_out-th act is popped;
//   DONE -> IDLE next cycle; done=1 only while in DONE. start outside IDLE ignored.
// - Handshakes: transfer when valid&ready at rising edge. act_valid/act_out held stable until act_ready.
// - psum_ready = (state==DRAIN) & (accepted < cfg_num_out) & (fifo_count + inflight < FIFO_DEPTH); no overflow possible.
// - Pipeline: S1 registers psum; S2 computes round/shift/sat/(relu) and writes FIFO. Accept at edge E => act_valid from edge E+2
//   when FIFO empty. Full throughput: 1 psum/cycle with act_ready=1.
// - FIFO is show-ahead; simultaneous push and pop allowed when full-minus-inflight rule permits; order strictly preserved.
// - Arithmetic (INTER_BITWIDTH+1 bits internal, no intermediate overflow):
//   r = (cfg_shift==0) ? psum : (psum + (1<<(cfg_shift-1))) >>> cfg_shift  (round half up, arithmetic shift)
//   act = clamp(r, -2^(ACT_BITWIDTH-1), 2^(ACT_BITWIDTH-1)-1); clamping sets sat_flag.
// - Counters: accepted and popped count to cfg_num_out; no wrap (CNT_BITWIDTH max job size).
// CONFIGURATION
// - RELU_EN defined: after clamp, negative act forced to 0 in S2; clamp of negatives does not set sat_flag (only positive clamp does).
// - RELU_EN undefined: signed output passes unchanged; no relu logic synthesized.
// TESTING
// - Reset/idle: reset held 2 cycles -> all outputs 0; psum_valid=1 in IDLE -> psum_ready stays 0.
// - Rounding: shift=4, num_out=2, psums 100, -100 -> acts 6, -6 (RELU_EN: 6, 0); act_valid at E+2; done after 2nd pop.
// - Saturation: shift=0, psums 2^40, -2^40 -> 32767, -32768; sat_flag=1 sticky until next start.
// - Backpressure: FIFO_DEPTH=8, act_ready=0, 12 psums offered -> exactly 8 accepted, psum_ready=0; release -> 12 outputs in order.
// - Zero/edge jobs: num_out=0 -> done next cycle after start; start while busy ignored; reset mid-job -> no done, outputs 0.
// - Max shift: shift=63, psum=2^63 -> act 1; psum=-(2^63) -> act -1.

Source files
------------

// File: rtl/psum_drain.sv
// Drain stage of the pointwise systolic array: requantizes partial sums and streams them out via a FIFO.
// Optional macro RELU_EN: forces negative activations to zero after clamping.
module psum_drain #(
   parameter int INTER_BITWIDTH = 65,
   parameter int ACT_BITWIDTH   = 16,
   parameter int SHIFT_BITWIDTH = 6,
   parameter int CNT_BITWIDTH   = 16,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SHIFT_BITWIDTH-1:0] cfg_shift,
   input  logic [CNT_BITWIDTH-1:0]   cfg_num_out,
   input  logic                      psum_valid,
   output logic                      psum_ready,
   input  logic [INTER_BITWIDTH-1:0] psum_in,
   output logic                      act_valid,
   input  logic                      act_ready,
   output logic [ACT_BITWIDTH-1:0]   act_out,
   output logic                      busy,
   output logic                      done,
   output logic                      sat_flag
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;
   localparam int XW = INTER_BITWIDTH + 1;

   localparam logic signed [XW-1:0] ACT_MAX = {{(XW-ACT_BITWIDTH+1){1'b0}}, {(ACT_BITWIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] ACT_MIN = {{(XW-ACT_BITWIDTH+1){1'b1}}, {(ACT_BITWIDTH-1){1'b0}}};
   localparam logic signed [XW-1:0] RND_ONE = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [SHIFT_BITWIDTH-1:0] SH_ONE  = {{(SHIFT_BITWIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_BITWIDTH-1:0]   CNT_ONE = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]             PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [OW-1:0]             OCC_ONE = {{(OW-1){1'b0}}, 1'b1};
   localparam logic [OW-1:0]             OCC_MAX = OW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, next_state;

   logic [SHIFT_BITWIDTH-1:0] shift_r;
   logic [CNT_BITWIDTH-1:0]   num_r;
   logic [CNT_BITWIDTH-1:0]   accepted_r;
   logic [CNT_BITWIDTH-1:0]   popped_r;
   logic                      s1_valid_r;
   logic [INTER_BITWIDTH-1:0] s1_data_r;
   logic                      s2_valid_r;
   logic [ACT_BITWIDTH-1:0]   s2_data_r;
   logic [ACT_BITWIDTH-1:0]   mem_r [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr_r;
   logic [PW-1:0]             rd_ptr_r;
   logic [OW-1:0]             count_r;
   logic                      sat_r;

   logic                      start_acc_s;
   logic                      psum_xfer_s;
   logic                      pop_s;
   logic [OW-1:0]             occupancy_s;
   logic signed [XW-1:0]      ext_s;
   logic signed [XW-1:0]      rnd_s;
   logic signed [XW-1:0]      sum_s;
   logic signed [XW-1:0]      shifted_s;
   logic [ACT_BITWIDTH-1:0]   q_s;
   logic                      sat_hit_s;

   assign start_acc_s = start && (state == IDLE);
   // Occupancy counts results still in the pipeline, so a full FIFO can never be overrun.
   assign occupancy_s = count_r + (s1_valid_r ? OCC_ONE : {OW{1'b0}})
                                + (s2_valid_r ? OCC_ONE : {OW{1'b0}});
   assign psum_ready  = (state == DRAIN) && (accepted_r < num_r) && (occupancy_s < OCC_MAX);
   assign psum_xfer_s = psum_valid && psum_ready;
   assign act_valid   = (count_r != {OW{1'b0}});
   assign act_out     = act_valid ? mem_r[rd_ptr_r] : {ACT_BITWIDTH{1'b0}};
   assign pop_s       = act_valid && act_ready;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign sat_flag    = sat_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) next_state = (cfg_num_out == {CNT_BITWIDTH{1'b0}}) ? DONE : DRAIN;
            else       next_state = IDLE;
         end
         DRAIN: begin
            if (pop_s && ((popped_r + CNT_ONE) == num_r)) next_state = DONE;
            else                                          next_state = DRAIN;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Job configuration, handshake counters and sticky saturation flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_r    <= {SHIFT_BITWIDTH{1'b0}};
         num_r      <= {CNT_BITWIDTH{1'b0}};
         accepted_r <= {CNT_BITWIDTH{1'b0}};
         popped_r   <= {CNT_BITWIDTH{1'b0}};
         sat_r      <= 1'b0;
      end else if (start_acc_s) begin
         shift_r    <= cfg_shift;
         num_r      <= cfg_num_out;
         accepted_r <= {CNT_BITWIDTH{1'b0}};
         popped_r   <= {CNT_BITWIDTH{1'b0}};
         sat_r      <= 1'b0;
      end else begin
         if (psum_xfer_s) accepted_r <= accepted_r + CNT_ONE;
         if (pop_s)       popped_r   <= popped_r + CNT_ONE;
         if (s1_valid_r && sat_hit_s) sat_r <= 1'b1;
      end
   end

   // Requantize: round half up, arithmetic shift, clamp to activation range.
   always_comb begin
      ext_s = {s1_data_r[INTER_BITWIDTH-1], s1_data_r};
      if (shift_r != {SHIFT_BITWIDTH{1'b0}}) rnd_s = RND_ONE <<< (shift_r - SH_ONE);
      else                                   rnd_s = {XW{1'b0}};
      sum_s     = ext_s + rnd_s;
      shifted_s = sum_s >>> shift_r;
      q_s       = shifted_s[ACT_BITWIDTH-1:0];
      sat_hit_s = 1'b0;
      if (shifted_s > ACT_MAX) begin
         q_s       = ACT_MAX[ACT_BITWIDTH-1:0];
         sat_hit_s = 1'b1;
      end else if (shifted_s < ACT_MIN) begin
         q_s       = ACT_MIN[ACT_BITWIDTH-1:0];
`ifdef RELU_EN
         sat_hit_s = 1'b0;
`else
         sat_hit_s = 1'b1;
`endif
      end else begin
         q_s       = shifted_s[ACT_BITWIDTH-1:0];
      end
`ifdef RELU_EN
      if (q_s[ACT_BITWIDTH-1]) q_s = {ACT_BITWIDTH{1'b0}};
      else                     q_s = q_s;
`endif
   end

   // Two-stage pipeline: S1 captures the psum, S2 holds the requantized activation.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {INTER_BITWIDTH{1'b0}};
         s2_valid_r <= 1'b0;
         s2_data_r  <= {ACT_BITWIDTH{1'b0}};
      end else begin
         s1_valid_r <= psum_xfer_s;
         if (psum_xfer_s) s1_data_r <= psum_in;
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r)  s2_data_r <= q_s;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {OW{1'b0}};
      end else begin
         if (s2_valid_r) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)      rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({s2_valid_r, pop_s})
            2'b10:   count_r <= count_r + OCC_ONE;
            2'b01:   count_r <= count_r - OCC_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; stale entries are masked by act_valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (s2_valid_r) mem_r[wr_ptr_r] <= s2_data_r;
   end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: randomized jobs against an arithmetic reference model.
module tb_psum_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  cfg_shift;
   logic [15:0] cfg_num_out;
   logic        psum_valid;
   logic        psum_ready;
   logic [64:0] psum_in;
   logic        act_valid;
   logic        act_ready;
   logic [15:0] act_out;
   logic        busy;
   logic        done;
   logic        sat_flag;

   int errors = 0;
   int checks = 0;

   logic signed [64:0] in_q  [$];
   logic        [15:0] exp_q [$];
   logic        [15:0] got_q [$];
   int  done_cnt;
   bit  timed_out;
   bit  exp_sat;

   psum_drain dut (
      .clk(clk), .reset(reset), .start(start), .cfg_shift(cfg_shift), .cfg_num_out(cfg_num_out),
      .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
      .act_valid(act_valid), .act_ready(act_ready), .act_out(act_out),
      .busy(busy), .done(done), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   // Floor((p + 2^(sh-1)) / 2^sh) then clamp, using wide integer division.
   function automatic void ref_q(input logic signed [64:0] p, input int sh,
                                 output logic [15:0] act, output bit sat);
      logic signed [127:0] n, d, q, r;
      n = p;
      sat = 1'b0;
      if (sh == 0) begin
         q = n;
      end else begin
         d = 128'sd1 <<< sh;
         n = n + (d >>> 1);
         q = n / d;
         r = n % d;
         if (r != 128'sd0 && n < 128'sd0) q = q - 128'sd1;
      end
      if (q > 128'sd32767) begin
         act = 16'h7fff; sat = 1'b1;
      end else if (q < -128'sd32768) begin
         act = 16'h8000;
`ifndef RELU_EN
         sat = 1'b1;
`endif
      end else begin
         act = q[15:0];
      end
`ifdef RELU_EN
      if (act[15]) act = 16'h0000;
`endif
   endfunction

   task automatic clear_model();
      in_q.delete(); exp_q.delete(); got_q.delete();
      done_cnt = 0; timed_out = 1'b0; exp_sat = 1'b0;
   endtask

   task automatic load(input logic signed [64:0] p, input int sh);
      logic [15:0] a;
      bit s;
      ref_q(p, sh, a, s);
      in_q.push_back(p);
      exp_q.push_back(a);
      exp_sat = exp_sat | s;
   endtask

   task automatic start_job(input int sh, input int n);
      @(negedge clk);
      start = 1'b1; cfg_shift = sh[5:0]; cfg_num_out = n[15:0];
      psum_valid = 1'b0; act_ready = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Drives queued psums and collects popped acts until done or the cycle budget runs out.
   task automatic stream(input int rdy_pct, input int max_cyc);
      timed_out = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++; psum_valid = 1'b0; act_ready = 1'b0; timed_out = 1'b0;
            break;
         end
         psum_valid = (in_q.size() > 0);
         psum_in    = psum_valid ? in_q[0] : 65'd0;
         act_ready  = (int'($urandom_range(99)) < rdy_pct);
         #1;
         if (psum_valid && psum_ready) void'(in_q.pop_front());
         if (act_valid && act_ready)   got_q.push_back(act_out);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; cfg_shift = 6'd0; cfg_num_out = 16'd0;
      psum_valid = 1'b0; psum_in = 65'd0; act_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({psum_ready, act_valid, act_out, busy, done, sat_flag} !== 21'd0)
         $display("FAIL reset_outputs: got %h expected 0", {psum_ready, act_valid, act_out, busy, done, sat_flag});
      reset = 1'b0;
      psum_valid = 1'b1; psum_in = 65'd55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (psum_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready: got %b expected 0", psum_ready);
         end
      end
      psum_valid = 1'b0;
   endtask

   task automatic test_rounding();
      logic [15:0] e0, e1;
      bit s;
      ref_q(65'sd100, 4, e0, s);
      ref_q(-65'sd100, 4, e1, s);
      start_job(4, 2);
      @(negedge clk);
      psum_valid = 1'b1; psum_in = 65'sd100; act_ready = 1'b0; #1;
      checks++;
      if (psum_ready !== 1'b1) begin errors++; $display("FAIL round_ready: got %b expected 1", psum_ready); end
      @(negedge clk);
      psum_in = -65'sd100;
      checks++;
      if (act_valid !== 1'b0) begin errors++; $display("FAIL round_lat_e1: got %b expected 0", act_valid); end
      @(negedge clk);
      psum_valid = 1'b0;
      checks++;
      if (act_valid !== 1'b0) begin errors++; $display("FAIL round_lat_e2: got %b expected 0", act_valid); end
      @(negedge clk);
      checks++;
      if (act_valid !== 1'b1 || act_out !== e0) begin
         errors++; $display("FAIL round_first: got v=%b %0d expected v=1 %0d", act_valid, $signed(act_out), $signed(e0));
      end
      act_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (act_valid !== 1'b1 || act_out !== e1 || done !== 1'b0) begin
         errors++; $display("FAIL round_second: got v=%b %0d d=%b expected v=1 %0d d=0", act_valid, $signed(act_out), done, $signed(e1));
      end
      @(negedge clk);
      act_ready = 1'b0;
      checks++;
      if (done !== 1'b1 || act_valid !== 1'b0) begin
         errors++; $display("FAIL round_done: got done=%b v=%b expected done=1 v=0", done, act_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL round_idle: got done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_saturation();
      clear_model();
      load(65'sd1099511627776, 0);
      load(-65'sd1099511627776, 0);
      start_job(0, 2);
      stream(100, 100);
      checks++;
      if (timed_out || done_cnt !== 1 || got_q.size() !== 2) begin
         errors++; $display("FAIL sat_job: got outputs=%0d done=%0d expected 2 1", got_q.size(), done_cnt);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", sat_flag); end
   endtask

   task automatic test_backpressure();
      int sh;
      logic [95:0] t;
      sh = int'($urandom_range(20));
      clear_model();
      for (int i = 0; i < 12; i++) begin
         t = {$urandom, $urandom, $urandom};
         load($signed(t[64:0]) >>> 30, sh);
      end
      start_job(sh, 12);
      stream(0, 20);
      checks++;
      if (12 - in_q.size() !== 8 || psum_ready !== 1'b0 || act_valid !== 1'b1) begin
         errors++; $display("FAIL bp_accepted: got %0d ready=%b expected 8 ready=0", 12 - in_q.size(), psum_ready);
      end
      stream(100, 200);
      checks++;
      if (timed_out || done_cnt !== 1 || got_q.size() !== 12) begin
         errors++; $display("FAIL bp_job: got outputs=%0d done=%0d expected 12 1", got_q.size(), done_cnt);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
         end
      end
   endtask

   task automatic test_zero_job();
      start_job(0, 0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || psum_ready !== 1'b0) begin
         errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1 1", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_idle: got done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_start_ignored();
      clear_model();
      load(65'sd1000, 2); load(-65'sd7, 2); load(65'sd6, 2);
      start_job(2, 3);
      @(negedge clk);
      start = 1'b1; cfg_num_out = 16'd0; cfg_shift = 6'd0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL busy_start: got busy=%b done=%b expected 1 0", busy, done);
      end
      stream(100, 100);
      checks++;
      if (timed_out || done_cnt !== 1 || got_q.size() !== 3) begin
         errors++; $display("FAIL busy_job: got outputs=%0d done=%0d expected 3 1", got_q.size(), done_cnt);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL busy_data[%0d]: got %0d expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
         end
      end
   endtask

   task automatic test_reset_midjob();
      int seen;
      clear_model();
      for (int i = 0; i < 5; i++) load(65'sd300 * i, 3);
      start_job(3, 5);
      stream(0, 4);
      @(negedge clk);
      reset = 1'b1; psum_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({psum_ready, act_valid, act_out, busy, done, sat_flag} !== 21'd0) begin
         errors++; $display("FAIL midreset_outputs: got %h expected 0", {psum_ready, act_valid, act_out, busy, done, sat_flag});
      end
      act_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || act_valid) seen++;
      end
      act_ready = 1'b0;
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d events expected 0", seen); end
   endtask

   task automatic test_max_shift();
      clear_model();
      load(65'sh0_8000_0000_0000_0000, 63);
      load(65'sh1_8000_0000_0000_0000, 63);
      start_job(63, 2);
      stream(100, 100);
      checks++;
      if (timed_out || got_q.size() !== 2) begin
         errors++; $display("FAIL maxsh_job: got outputs=%0d expected 2", got_q.size());
      end
      checks++;
      if (got_q.size() > 0 && got_q[0] !== 16'd1) begin
         errors++; $display("FAIL maxsh_pos: got %0d expected 1", $signed(got_q[0]));
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL maxsh_data[%0d]: got %0d expected %0d", i, $signed(got_q[i]), $signed(exp_q[i]));
         end
      end
   endtask

   task automatic test_random();
      int sh, n, pct;
      logic [95:0] t;
      for (int j = 0; j < 6; j++) begin
         sh  = int'($urandom_range(63));
         n   = int'($urandom_range(20, 1));
         pct = int'($urandom_range(100, 30));
         clear_model();
         for (int i = 0; i < n; i++) begin
            t = {$urandom, $urandom, $urandom};
            load($signed(t[64:0]) >>> $urandom_range(64), sh);
         end
         start_job(sh, n);
         checks++;
         if (sat_flag !== 1'b0) begin errors++; $display("FAIL rand_sat_clear: got %b expected 0", sat_flag); end
         stream(pct, 2000);
         checks++;
         if (timed_out || done_cnt !== 1 || got_q.size() !== n) begin
            errors++; $display("FAIL rand_job%0d: got outputs=%0d done=%0d expected %0d 1", j, got_q.size(), done_cnt, n);
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rand_data%0d[%0d]: got %0d expected %0d", j, i, $signed(got_q[i]), $signed(exp_q[i]));
            end
         end
         checks++;
         if (sat_flag !== exp_sat) begin
            errors++; $display("FAIL rand_sat%0d: got %b expected %b", j, sat_flag, exp_sat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_random();
      test_backpressure();
      test_zero_job();
      test_start_ignored();
      test_reset_midjob();
      test_max_shift();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
